// File: rtl/mem_pkg.sv
// mem_pkg: shared funct3 codes, FSM states and beat bundle for unified_mem_ctrl.
// Optional build macro used by the controller: MISALIGN_TRAP_EN.
package mem_pkg;

  localparam logic [2:0] F3_B  = 3'd0;
  localparam logic [2:0] F3_H  = 3'd1;
  localparam logic [2:0] F3_W  = 3'd2;
  localparam logic [2:0] F3_BU = 3'd4;
  localparam logic [2:0] F3_HU = 3'd5;

  typedef enum logic {
    IDLE,
    BEAT2
  } state_e;

  typedef struct packed {
    logic        fetch;
    logic        we;
    logic [2:0]  f3;
    logic [1:0]  off;
    logic [2:0]  size;
    logic [31:0] lo;
    logic [31:0] wdata;
  } beat_t;

  function automatic logic [2:0] size_of(input logic [2:0] f3);
    case (f3)
      F3_B, F3_BU: return 3'd1;
      F3_H, F3_HU: return 3'd2;
      F3_W:        return 3'd4;
      default:     return 3'd0;
    endcase
  endfunction

endpackage

// File: rtl/mem_lane_align.sv
// mem_lane_align: byte-lane steering between a byte access and two words.
// Produces per-beat byte enables/write data and the extended read result.
module mem_lane_align
  import mem_pkg::*;
(
  input  logic [1:0]  i_off,
  input  logic [2:0]  i_size,
  input  logic [2:0]  i_func3,
  input  logic [31:0] i_wdata,
  input  logic [31:0] i_lo,
  input  logic [31:0] i_hi,
  output logic [3:0]  o_be0,
  output logic [3:0]  o_be1,
  output logic [31:0] o_wd0,
  output logic [31:0] o_wd1,
  output logic [31:0] o_rdata
);

  logic [7:0]  w_mask;
  logic [63:0] w_wd;
  logic [31:0] w_raw;
  logic [4:0]  w_sh;

  assign w_sh = {i_off, 3'b000};

  // Lane mask and store data spread across the two words
  always_comb begin
    w_mask = 8'h00;
    case (i_size)
      3'd1:    w_mask = 8'h01;
      3'd2:    w_mask = 8'h03;
      3'd4:    w_mask = 8'h0F;
      default: w_mask = 8'h00;
    endcase
    w_mask = w_mask << i_off;
    w_wd   = {32'h0, i_wdata} << w_sh;
    o_be0  = w_mask[3:0];
    o_be1  = w_mask[7:4];
    o_wd0  = w_wd[31:0];
    o_wd1  = w_wd[63:32];
  end

  // Gather the addressed bytes and extend per load type
  always_comb begin
    w_raw = 32'(({i_hi, i_lo}) >> w_sh);
    case (i_func3)
      F3_B:    o_rdata = {{24{w_raw[7]}}, w_raw[7:0]};
      F3_H:    o_rdata = {{16{w_raw[15]}}, w_raw[15:0]};
      F3_BU:   o_rdata = {24'h0, w_raw[7:0]};
      F3_HU:   o_rdata = {16'h0, w_raw[15:0]};
      default: o_rdata = w_raw;
    endcase
  end

endmodule

// File: rtl/unified_mem_ctrl.sv
// unified_mem_ctrl: word memory shared by fetch and data ports, data first.
// Define MISALIGN_TRAP_EN to trap misaligned data instead of splitting it.
module unified_mem_ctrl
  import mem_pkg::*;
#(
  parameter int XLEN        = 32,
  parameter int DEPTH       = 128,
  parameter int ADDR_W      = 9,
  parameter int INST_OFFSET = 256
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic              i_ready,
  output logic              i_rvalid,
  output logic [XLEN-1:0]   i_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [2:0]        d_func3,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [XLEN-1:0]   d_wdata,
  output logic              d_ready,
  output logic              d_rvalid,
  output logic [XLEN-1:0]   d_rdata,
  output logic              d_err
);

  localparam int IW = ADDR_W - 2;
  localparam logic [ADDR_W-1:0] LP_IOFF = ADDR_W'(INST_OFFSET);

  logic [XLEN-1:0] r_mem [DEPTH];
  state_e          r_state;
  state_e          w_state_nx;
  logic            r_rdy;
  beat_t           r_pend;
  logic [IW-1:0]   r_w1;
  logic            r_i_rvalid;
  logic            r_d_rvalid;
  logic            r_d_err;
  logic [XLEN-1:0] r_i_rdata;
  logic [XLEN-1:0] r_d_rdata;

  logic [ADDR_W-1:0] w_i_baddr;
  logic              w_d_acc;
  logic              w_i_acc;
  logic [2:0]        w_d_size;
  logic              w_d_ill;
  logic              w_d_mis;
  logic              w_d_trap;
  logic              w_d_err;
  logic              w_i_mis;
  logic [1:0]        w_off;
  logic [2:0]        w_size;
  logic [2:0]        w_f3;
  logic [IW-1:0]     w_idx;
  logic [IW-1:0]     w_idx1;
  logic [XLEN-1:0]   w_wdata;
  logic [XLEN-1:0]   w_lo;
  logic [XLEN-1:0]   w_hi;
  logic [3:0]        w_be0;
  logic [3:0]        w_be1;
  logic [XLEN-1:0]   w_wd0;
  logic [XLEN-1:0]   w_wd1;
  logic [XLEN-1:0]   w_ext;
  logic              w_wr1;
  logic              w_wr2;

  assign w_i_baddr = i_addr + LP_IOFF;
  assign w_d_acc   = d_req & r_rdy;
  assign w_i_acc   = i_req & r_rdy & ~d_req;
  assign w_d_size  = size_of(d_func3);
  assign w_d_ill   = d_we ? (d_func3 > F3_W)
                          : (d_func3 == 3'd3 || d_func3 > F3_HU);
  assign w_d_mis   = ({2'b00, d_addr[1:0]} + {1'b0, w_d_size}) > 4'd4;
  assign w_i_mis   = w_i_baddr[1:0] != 2'b00;
`ifdef MISALIGN_TRAP_EN
  assign w_d_trap  = w_d_mis;
`else
  assign w_d_trap  = 1'b0;
`endif
  assign w_d_err   = w_d_ill | w_d_trap;

  // Operand set for the beat being serviced this cycle
  always_comb begin
    w_off   = d_addr[1:0];
    w_size  = w_d_size;
    w_f3    = d_func3;
    w_idx   = d_addr[ADDR_W-1:2];
    w_wdata = d_wdata;
    if (r_state == BEAT2) begin
      w_off   = r_pend.off;
      w_size  = r_pend.size;
      w_f3    = r_pend.f3;
      w_wdata = r_pend.wdata;
    end else if (!w_d_acc) begin
      w_off   = w_i_baddr[1:0];
      w_size  = 3'd4;
      w_f3    = F3_W;
      w_idx   = w_i_baddr[ADDR_W-1:2];
      w_wdata = '0;
    end
  end

  assign w_idx1 = w_idx + IW'(1);
  assign w_lo   = (r_state == BEAT2) ? r_pend.lo : r_mem[w_idx];
  assign w_hi   = r_mem[r_w1];

  mem_lane_align u_align (
    .i_off   (w_off),
    .i_size  (w_size),
    .i_func3 (w_f3),
    .i_wdata (w_wdata),
    .i_lo    (w_lo),
    .i_hi    (w_hi),
    .o_be0   (w_be0),
    .o_be1   (w_be1),
    .o_wd0   (w_wd0),
    .o_wd1   (w_wd1),
    .o_rdata (w_ext)
  );

  // Next state and store-beat write strobes
  always_comb begin
    w_state_nx = r_state;
    w_wr1      = 1'b0;
    w_wr2      = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_d_acc) begin
          w_wr1 = d_we & ~w_d_err;
          if (!w_d_err && w_d_mis) w_state_nx = BEAT2;
        end else if (w_i_acc && w_i_mis) begin
          w_state_nx = BEAT2;
        end
      end
      BEAT2: begin
        w_state_nx = IDLE;
        w_wr2      = r_pend.we & ~r_pend.fetch;
      end
    endcase
  end

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_nx;
  end

  // Byte-lane writes; a reset edge suppresses any pending beat
  always_ff @(posedge clk) begin
    if (!rst && w_wr1) begin
      for (int b = 0; b < 4; b++)
        if (w_be0[b]) r_mem[w_idx][8*b +: 8] <= w_wd0[8*b +: 8];
    end
    if (!rst && w_wr2) begin
      for (int b = 0; b < 4; b++)
        if (w_be1[b]) r_mem[r_w1][8*b +: 8] <= w_wd1[8*b +: 8];
    end
  end

  // Responses, ready, and capture of the first beat of a split access
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rdy      <= 1'b0;
      r_i_rvalid <= 1'b0;
      r_d_rvalid <= 1'b0;
      r_d_err    <= 1'b0;
      r_i_rdata  <= '0;
      r_d_rdata  <= '0;
      r_pend     <= '0;
      r_w1       <= '0;
    end else begin
      r_rdy      <= (w_state_nx == IDLE) && (r_state == IDLE);
      r_i_rvalid <= 1'b0;
      r_d_rvalid <= 1'b0;
      r_d_err    <= 1'b0;
      if (r_state == BEAT2) begin
        if (r_pend.fetch) begin
          r_i_rvalid <= 1'b1;
          r_i_rdata  <= w_ext;
        end else begin
          r_d_rvalid <= 1'b1;
          r_d_rdata  <= r_pend.we ? '0 : w_ext;
        end
      end else if (w_d_acc) begin
        if (w_d_err) begin
          r_d_rvalid <= 1'b1;
          r_d_err    <= 1'b1;
          r_d_rdata  <= '0;
        end else if (w_d_mis) begin
          r_pend <= '{fetch: 1'b0, we: d_we, f3: d_func3,
                      off: d_addr[1:0], size: w_d_size,
                      lo: w_lo, wdata: d_wdata};
          r_w1   <= w_idx1;
        end else begin
          r_d_rvalid <= 1'b1;
          r_d_rdata  <= d_we ? '0 : w_ext;
        end
      end else if (w_i_acc) begin
        if (w_i_mis) begin
          r_pend <= '{fetch: 1'b1, we: 1'b0, f3: F3_W,
                      off: w_i_baddr[1:0], size: 3'd4,
                      lo: w_lo, wdata: 32'h0};
          r_w1   <= w_idx1;
        end else begin
          r_i_rvalid <= 1'b1;
          r_i_rdata  <= w_ext;
        end
      end
    end
  end

  assign d_ready  = r_rdy;
  assign i_ready  = r_rdy & ~d_req;
  assign i_rvalid = r_i_rvalid;
  assign i_rdata  = r_i_rdata;
  assign d_rvalid = r_d_rvalid;
  assign d_rdata  = r_d_rdata;
  assign d_err    = r_d_err;

endmodule
